// File: rtl/instr_seq_ctrl.sv
// Instruction-cycle controller for the 8-bit accumulator CPU: IDLE, S0..S7, HALT.
// Optional single-step mode (step input + WAIT state) is enabled by defining CTRL_STEP_EN.
module instr_seq_ctrl #(
   parameter int OPW  = 3,
   parameter int ST_W = 4
) (
   input  logic           clk,
   input  logic           i_reset,
   input  logic           i_fetch,
   input  logic [OPW-1:0] i_opcode,
   input  logic           i_zero,
`ifdef CTRL_STEP_EN
   input  logic           i_step,
`endif
   output logic           o_inc_pc,
   output logic           o_load_pc,
   output logic           o_load_ir,
   output logic           o_load_acc,
   output logic           o_rd,
   output logic           o_wr,
   output logic           o_datactl_ena,
   output logic           o_halt
);

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 4'd0,
      ST_S0   = 4'd1,
      ST_S1   = 4'd2,
      ST_S2   = 4'd3,
      ST_S3   = 4'd4,
      ST_S4   = 4'd5,
      ST_S5   = 4'd6,
      ST_S6   = 4'd7,
      ST_S7   = 4'd8,
      ST_HALT = 4'd9
`ifdef CTRL_STEP_EN
      ,
      ST_WAIT = 4'd10
`endif
   } state_e;

   typedef enum logic [OPW-1:0] {
      OP_HLT  = 3'd0,
      OP_SKZ  = 3'd1,
      OP_ADD  = 3'd2,
      OP_ANDD = 3'd3,
      OP_XORR = 3'd4,
      OP_LDA  = 3'd5,
      OP_STO  = 3'd6,
      OP_JMP  = 3'd7
   } op_e;

   state_e r_state;
   state_e w_next;
   op_e    r_op;
   logic   w_aluop;
   logic   w_skz_taken;

   always_ff @(posedge clk) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_op    <= OP_HLT;
      end else begin
         r_state <= w_next;
         // Opcode is captured as the sequence leaves S2 and held for the rest of it.
         if (r_state == ST_S2)
            r_op <= op_e'(i_opcode);
      end
   end

   assign w_aluop     = (r_op == OP_ADD) || (r_op == OP_ANDD) ||
                        (r_op == OP_XORR) || (r_op == OP_LDA);
   assign w_skz_taken = (r_op == OP_SKZ) && i_zero;

   always_comb begin
      // NOTE: every output and the next state get a default first, so no path can infer a latch.
      w_next        = r_state;
      o_inc_pc      = 1'b0;
      o_load_pc     = 1'b0;
      o_load_ir     = 1'b0;
      o_load_acc    = 1'b0;
      o_rd          = 1'b0;
      o_wr          = 1'b0;
      o_datactl_ena = 1'b0;
      o_halt        = 1'b0;
      case (r_state)
         ST_IDLE: if (i_fetch) w_next = ST_S0;
         ST_S0: begin
            o_rd      = 1'b1;
            o_load_ir = 1'b1;
            w_next    = ST_S1;
         end
         ST_S1: begin
            o_rd      = 1'b1;
            o_load_ir = 1'b1;
            o_inc_pc  = 1'b1;
            w_next    = ST_S2;
         end
         ST_S2: w_next = ST_S3;
         ST_S3: begin
            o_inc_pc = 1'b1;
            if (r_op == OP_HLT) begin
               o_halt = 1'b1;
               w_next = ST_HALT;
            end else begin
               w_next = ST_S4;
            end
         end
         ST_S4: begin
            o_rd          = w_aluop;
            o_inc_pc      = w_skz_taken;
            o_load_pc     = (r_op == OP_JMP);
            o_datactl_ena = (r_op == OP_STO);
            w_next        = ST_S5;
         end
         ST_S5: begin
            o_rd          = w_aluop;
            o_load_acc    = w_aluop;
            o_inc_pc      = w_skz_taken || (r_op == OP_JMP);
            o_load_pc     = (r_op == OP_JMP);
            o_wr          = (r_op == OP_STO);
            o_datactl_ena = (r_op == OP_STO);
            w_next        = ST_S6;
         end
         ST_S6: begin
            o_rd          = w_aluop;
            o_datactl_ena = (r_op == OP_STO);
            w_next        = ST_S7;
         end
         ST_S7: begin
            o_inc_pc = w_skz_taken;
`ifdef CTRL_STEP_EN
            w_next   = ST_WAIT;
`else
            w_next   = ST_S0;
`endif
         end
         ST_HALT: begin
            o_halt = 1'b1;
            w_next = ST_HALT;
         end
`ifdef CTRL_STEP_EN
         ST_WAIT: if (i_step) w_next = ST_S0;
`endif
         default: w_next = ST_IDLE;
      endcase
   end

endmodule
